mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the instruction-fetch requester (PC side) and the data load/store requester (Mem_RW / Write_Strobe side) of the core.
- Sits between the CU/datapath and the unified memory.
- Arbitrates with data-over-fetch priority plus an anti-starvation limit.
- Sequences one outstanding access at a time, returns read data with a valid pulse, and aborts hung accesses on timeout.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data, memory and status signals around the memory port
// arbiter. The arbiter connects through the slave modport; the requesters and
// the memory connect through the master modport.
interface mem_port_arbiter_if;
  // Instruction-fetch requester
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  // Data load/store requester
  logic        d_valid;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_strobe;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  // Shared memory port
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_strobe;
  logic        m_ack;
  logic [31:0] m_rdata;
  // Status
  logic        err;
  logic        busy;

  modport slave (
    input  if_valid, if_addr, d_valid, d_we, d_addr, d_wdata, d_strobe,
           m_ack, m_rdata,
    output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           m_req, m_we, m_addr, m_wdata, m_strobe, err, busy
  );

  modport master (
    output if_valid, if_addr, d_valid, d_we, d_addr, d_wdata, d_strobe,
           m_ack, m_rdata,
    input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           m_req, m_we, m_addr, m_wdata, m_strobe, err, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch
// and data load/store. Data wins over fetch unless fetch has waited through
// STARVE_LIMIT consecutive data grants. One access is outstanding at a time;
// an access that sees no m_ack for TIMEOUT cycles is aborted with err.
module mem_port_arbiter #(
  parameter int TIMEOUT      = 16,  // 2..255
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,                 // asynchronous, active-low
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [7:0]      TMO_LAST   = 8'(TIMEOUT - 1);

  state_e        state_q;
  logic [7:0]    tmo_q;
  logic [SW-1:0] starve_q;

  logic          m_req_q, m_we_q;
  logic [31:0]   m_addr_q, m_wdata_q;
  logic [1:0]    m_strobe_q;
  logic          if_rvalid_q, d_rvalid_q, err_q;
  logic [31:0]   if_rdata_q, d_rdata_q;

  logic          starve_hit;
  logic          if_ready_c, d_ready_c;
  logic          if_acc, d_acc;

  assign starve_hit = (starve_q == STARVE_MAX);
  assign if_acc     = bus.if_valid & if_ready_c;
  assign d_acc      = bus.d_valid & d_ready_c;

  // Grant decision: only in IDLE, data first unless fetch is being starved.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    if_ready_c = 1'b0;
    d_ready_c  = 1'b0;
    if (state_q == IDLE) begin
      d_ready_c  = bus.d_valid & ~(starve_hit & bus.if_valid);
      if_ready_c = bus.if_valid & (~bus.d_valid | starve_hit);
    end
  end

  // Access sequencer: accept, hold the memory request, complete or abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      starve_q    <= '0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_strobe_q  <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      err_q       <= 1'b0;

      // Count data grants that fetch has had to sit through.
      if (!bus.if_valid || if_acc)
        starve_q <= '0;
      else if (d_acc && !starve_hit)
        starve_q <= starve_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (if_acc) begin
            m_addr_q   <= bus.if_addr;
            m_we_q     <= 1'b0;
            m_wdata_q  <= '0;
            m_strobe_q <= 2'b10;
            m_req_q    <= 1'b1;
            tmo_q      <= '0;
            state_q    <= BUSY_I;
          end else if (d_acc) begin
            m_addr_q   <= bus.d_addr;
            m_we_q     <= bus.d_we;
            m_wdata_q  <= bus.d_wdata;
            // 11 is a word access, presented to memory as 10.
            m_strobe_q <= (bus.d_strobe == 2'b11) ? 2'b10 : bus.d_strobe;
            m_req_q    <= 1'b1;
            tmo_q      <= '0;
            state_q    <= BUSY_D;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.m_ack) begin
            // A late ack still beats the abort in the same cycle.
            m_req_q <= 1'b0;
            state_q <= IDLE;
            if (state_q == BUSY_I) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= bus.m_rdata;
            end else begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= m_we_q ? 32'h0 : bus.m_rdata;
            end
          end else if (tmo_q == TMO_LAST) begin
            m_req_q <= 1'b0;
            state_q <= IDLE;
            err_q   <= 1'b1;
            if (state_q == BUSY_I) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= '0;
            end else begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= '0;
            end
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_ready  = if_ready_c;
  assign bus.d_ready   = d_ready_c;
  assign bus.m_req     = m_req_q;
  assign bus.m_we      = m_we_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_strobe  = m_strobe_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs are driven on the falling edge
// and outputs are compared 1 time unit later, well away from the rising edge.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(16), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.if_valid = 1'b0; bus.if_addr = '0;
    bus.d_valid  = 1'b0; bus.d_we    = 1'b0; bus.d_addr = '0;
    bus.d_wdata  = '0;   bus.d_strobe = 2'b00;
    bus.m_ack    = 1'b0; bus.m_rdata  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (3) step();
    #1;
    checks++; if (bus.m_req !== 1'b0) begin failures++; $display("FAIL reset_m_req: got %0h exp 0", bus.m_req); end
    checks++; if (bus.m_addr !== 32'h0) begin failures++; $display("FAIL reset_m_addr: got %h exp 0", bus.m_addr); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0h exp 0", bus.busy); end
    checks++; if ({bus.if_rvalid, bus.d_rvalid, bus.err} !== 3'b000) begin failures++; $display("FAIL reset_pulses: got %b exp 000", {bus.if_rvalid, bus.d_rvalid, bus.err}); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    bus.if_valid = 1'b1; bus.if_addr = 32'h100; #1;
    checks++; if (bus.if_ready !== 1'b1) begin failures++; $display("FAIL fetch_ready: got %0h exp 1", bus.if_ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL fetch_busy_n: got %0h exp 0", bus.busy); end
    step();
    bus.if_valid = 1'b0; bus.m_ack = 1'b1; bus.m_rdata = 32'h0050_0093; #1;
    checks++; if (bus.m_req !== 1'b1) begin failures++; $display("FAIL fetch_m_req: got %0h exp 1", bus.m_req); end
    checks++; if (bus.m_addr !== 32'h100) begin failures++; $display("FAIL fetch_m_addr: got %h exp 00000100", bus.m_addr); end
    checks++; if ({bus.m_we, bus.m_strobe} !== 3'b010) begin failures++; $display("FAIL fetch_m_ctl: got %b exp 010", {bus.m_we, bus.m_strobe}); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL fetch_busy: got %0h exp 1", bus.busy); end
    step();
    bus.m_ack = 1'b0; bus.m_rdata = 32'hFFFF_FFFF; #1;
    checks++; if (bus.if_rvalid !== 1'b1) begin failures++; $display("FAIL fetch_rvalid: got %0h exp 1", bus.if_rvalid); end
    checks++; if (bus.if_rdata !== 32'h0050_0093) begin failures++; $display("FAIL fetch_rdata: got %h exp 00500093", bus.if_rdata); end
    checks++; if ({bus.m_req, bus.busy, bus.err} !== 3'b000) begin failures++; $display("FAIL fetch_done_state: got %b exp 000", {bus.m_req, bus.busy, bus.err}); end
    step(); #1;
    checks++; if (bus.if_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_rvalid_pulse: got %0h exp 0", bus.if_rvalid); end
    checks++; if (bus.if_rdata !== 32'h0050_0093) begin failures++; $display("FAIL fetch_rdata_hold: got %h exp 00500093", bus.if_rdata); end
  endtask

  task automatic test_ack_idle();
    step();
    bus.m_ack = 1'b1; bus.m_rdata = 32'h1234_5678;
    step();
    bus.m_ack = 1'b0; #1;
    checks++; if ({bus.m_req, bus.if_rvalid, bus.d_rvalid, bus.busy} !== 4'b0000) begin failures++; $display("FAIL idle_ack_ignored: got %b exp 0000", {bus.m_req, bus.if_rvalid, bus.d_rvalid, bus.busy}); end
  endtask

  task automatic test_simultaneous();
    step();
    bus.d_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000;
    bus.if_valid = 1'b1; bus.if_addr = 32'h104; #1;
    checks++; if ({bus.d_ready, bus.if_ready} !== 2'b10) begin failures++; $display("FAIL simul_grant_d: got %b exp 10", {bus.d_ready, bus.if_ready}); end
    step();
    bus.d_valid = 1'b0; bus.m_ack = 1'b1; bus.m_rdata = 32'h1111_2222; #1;
    checks++; if (bus.m_addr !== 32'h2000) begin failures++; $display("FAIL simul_d_addr: got %h exp 00002000", bus.m_addr); end
    checks++; if (bus.if_ready !== 1'b0) begin failures++; $display("FAIL simul_busy_no_ready: got %0h exp 0", bus.if_ready); end
    step();
    bus.m_ack = 1'b0; #1;
    checks++; if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h1111_2222}) begin failures++; $display("FAIL simul_d_done: got %0h/%h exp 1/11112222", bus.d_rvalid, bus.d_rdata); end
    checks++; if ({bus.if_ready, bus.m_req} !== 2'b10) begin failures++; $display("FAIL simul_grant_i: got %b exp 10", {bus.if_ready, bus.m_req}); end
    step();
    bus.if_valid = 1'b0; bus.m_ack = 1'b1; bus.m_rdata = 32'h3333_4444; #1;
    checks++; if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h104}) begin failures++; $display("FAIL simul_i_req: got %0h/%h exp 1/00000104", bus.m_req, bus.m_addr); end
    step();
    bus.m_ack = 1'b0; #1;
    checks++; if ({bus.if_rvalid, bus.if_rdata, bus.d_rvalid} !== {1'b1, 32'h3333_4444, 1'b0}) begin failures++; $display("FAIL simul_i_done: got %0h/%h/%0h exp 1/33334444/0", bus.if_rvalid, bus.if_rdata, bus.d_rvalid); end
  endtask

  task automatic test_starvation();
    byte grants [6];
    byte exp_g  [6];
    int  g;
    int  overlap;
    exp_g = '{"D", "D", "D", "D", "I", "D"};
    g = 0; overlap = 0;
    clear_inputs();
    step();
    for (int cyc = 0; cyc < 40 && g < 6; cyc++) begin
      bus.d_valid = 1'b1; bus.if_valid = 1'b1;
      bus.d_addr = 32'h5000; bus.if_addr = 32'h200;
      bus.m_ack = bus.m_req; bus.m_rdata = 32'hCAFE_0000 + 32'(cyc);
      #1;
      if (bus.if_ready && bus.d_ready) overlap++;
      if (bus.d_ready) begin grants[g] = "D"; g++; end
      else if (bus.if_ready) begin grants[g] = "I"; g++; end
      step();
    end
    bus.d_valid = 1'b0; bus.if_valid = 1'b0; bus.m_ack = 1'b1;
    step();
    bus.m_ack = 1'b0;
    checks++; if (g !== 6) begin failures++; $display("FAIL starve_grant_count: got %0d exp 6", g); end
    checks++; if (overlap !== 0) begin failures++; $display("FAIL starve_overlap: got %0d exp 0", overlap); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (grants[i] !== exp_g[i]) begin failures++; $display("FAIL starve_order[%0d]: got %c exp %c", i, grants[i], exp_g[i]); end
    end
    step();
  endtask

  task automatic test_store();
    bus.d_valid = 1'b1; bus.d_we = 1'b1; bus.d_strobe = 2'b01;
    bus.d_wdata = 32'hABCD; bus.d_addr = 32'h3002; #1;
    checks++; if (bus.d_ready !== 1'b1) begin failures++; $display("FAIL store_ready: got %0h exp 1", bus.d_ready); end
    step();
    clear_inputs(); #1;
    checks++; if ({bus.m_req, bus.m_we, bus.m_strobe} !== 4'b1101) begin failures++; $display("FAIL store_ctl: got %b exp 1101", {bus.m_req, bus.m_we, bus.m_strobe}); end
    checks++; if (bus.m_wdata !== 32'hABCD) begin failures++; $display("FAIL store_wdata: got %h exp 0000abcd", bus.m_wdata); end
    step();
    bus.m_ack = 1'b1; bus.m_rdata = 32'hDEAD_BEEF; #1;
    checks++; if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata} !== {2'b11, 32'h3002, 32'hABCD}) begin failures++; $display("FAIL store_stable: got %b %h %h exp 11 00003002 0000abcd", {bus.m_req, bus.m_we}, bus.m_addr, bus.m_wdata); end
    step();
    bus.m_ack = 1'b0; #1;
    checks++; if ({bus.d_rvalid, bus.err, bus.d_rdata} !== {2'b10, 32'h0}) begin failures++; $display("FAIL store_done: got %0h/%0h/%h exp 1/0/00000000", bus.d_rvalid, bus.err, bus.d_rdata); end
  endtask

  task automatic test_late_ack_wins();
    step();
    bus.d_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4000;
    step();
    clear_inputs();
    for (int i = 0; i < 15; i++) step();
    bus.m_ack = 1'b1; bus.m_rdata = 32'h7777_8888; #1;
    checks++; if (bus.m_req !== 1'b1) begin failures++; $display("FAIL late_ack_req: got %0h exp 1", bus.m_req); end
    step();
    bus.m_ack = 1'b0; #1;
    checks++; if ({bus.d_rvalid, bus.err, bus.d_rdata} !== {2'b10, 32'h7777_8888}) begin failures++; $display("FAIL late_ack_wins: got %0h/%0h/%h exp 1/0/77778888", bus.d_rvalid, bus.err, bus.d_rdata); end
  endtask

  task automatic test_timeout();
    int n;
    step();
    bus.d_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4004;
    step();
    clear_inputs();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!bus.m_req) break;
      n++;
      step();
    end
    checks++; if (n !== 16) begin failures++; $display("FAIL timeout_req_cycles: got %0d exp 16", n); end
    checks++; if ({bus.d_rvalid, bus.err, bus.busy} !== 3'b110) begin failures++; $display("FAIL timeout_abort: got %b exp 110", {bus.d_rvalid, bus.err, bus.busy}); end
    checks++; if (bus.d_rdata !== 32'h0) begin failures++; $display("FAIL timeout_rdata: got %h exp 00000000", bus.d_rdata); end
    step(); #1;
    checks++; if ({bus.d_rvalid, bus.err} !== 2'b00) begin failures++; $display("FAIL timeout_pulse: got %b exp 00", {bus.d_rvalid, bus.err}); end
  endtask

  task automatic test_reset_mid_access();
    step();
    bus.if_valid = 1'b1; bus.if_addr = 32'h180;
    step();
    bus.if_valid = 1'b0; #1;
    checks++; if (bus.m_req !== 1'b1) begin failures++; $display("FAIL rst_mid_pre: got %0h exp 1", bus.m_req); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({bus.m_req, bus.busy, bus.m_addr} !== {2'b00, 32'h0}) begin failures++; $display("FAIL rst_mid_async: got %b %h exp 00 00000000", {bus.m_req, bus.busy}, bus.m_addr); end
    step();
    bus.m_ack = 1'b1; #1;
    checks++; if (bus.if_rvalid !== 1'b0) begin failures++; $display("FAIL rst_mid_no_rvalid: got %0h exp 0", bus.if_rvalid); end
    step();
    bus.m_ack = 1'b0; rst = 1'b1; #1;
    checks++; if ({bus.if_rvalid, bus.m_req} !== 2'b00) begin failures++; $display("FAIL rst_release: got %b exp 00", {bus.if_rvalid, bus.m_req}); end
    bus.if_valid = 1'b1; bus.if_addr = 32'h200; #1;
    checks++; if (bus.if_ready !== 1'b1) begin failures++; $display("FAIL rst_new_ready: got %0h exp 1", bus.if_ready); end
    step();
    bus.if_valid = 1'b0; bus.m_ack = 1'b1; bus.m_rdata = 32'h0000_0013; #1;
    checks++; if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h200}) begin failures++; $display("FAIL rst_new_req: got %0h/%h exp 1/00000200", bus.m_req, bus.m_addr); end
    step();
    bus.m_ack = 1'b0; #1;
    checks++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'h13}) begin failures++; $display("FAIL rst_new_done: got %0h/%h exp 1/00000013", bus.if_rvalid, bus.if_rdata); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_fetch();
    test_ack_idle();
    test_simultaneous();
    test_starvation();
    test_store();
    test_late_ack_wins();
    test_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
